// File: rtl/sdp_nrdma_eg_pkg.sv
// SDP NRDMA egress shared definitions.
// Default FIFO geometry, payload type and width helper.
package sdp_nrdma_eg_pkg;

  localparam int WIDTH_DEF    = 256;
  localparam int DEPTH_DEF    = 4;
  localparam int AFULL_TH_DEF = 4;

  typedef logic [WIDTH_DEF-1:0] payload_t;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sdp_nrdma_eg_flopram_rwsa.sv
// Flop-based DEPTH x WIDTH RAM.
// Synchronous write, asynchronous read.
module sdp_nrdma_eg_flopram_rwsa
  import sdp_nrdma_eg_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = (DEPTH > 1) ? clog2(DEPTH) : 1
) (
  input  logic             nvdla_core_clk,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] di,
  input  logic [AW-1:0]    ra,
  output logic [WIDTH-1:0] dout,
  input  logic [31:0]      pwrbus_ram_pd
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             unused_pd;

  // Power-bus control has no meaning for flops.
  assign unused_pd = ^pwrbus_ram_pd;

  // Array write on accepted push.
  always_ff @(posedge nvdla_core_clk) begin
    if (we) mem[wa] <= di;
  end

  assign dout = mem[ra];

endmodule

// File: rtl/sdp_nrdma_eg_ro_pfifo.sv
// SDP NRDMA egress read-return FIFO.
// Flop array plus registered output stage.
module sdp_nrdma_eg_ro_pfifo
  import sdp_nrdma_eg_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int AFULL_TH = AFULL_TH_DEF,
  parameter int CNT_W    = clog2(DEPTH + 2)
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic             wr_pvld,
  output logic             wr_prdy,
  input  logic [WIDTH-1:0] wr_pd,
  output logic             rd_pvld,
  input  logic             rd_prdy,
  output logic [WIDTH-1:0] rd_pd,
  input  logic             flush,
  output logic [CNT_W-1:0] occupancy,
  output logic             almost_full,
  input  logic [31:0]      pwrbus_ram_pd
);

  localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH + 1);
  localparam logic [CNT_W-1:0] AFT  = CNT_W'(AFULL_TH);
  localparam logic [AW-1:0]    LAST = AW'(DEPTH - 1);

  logic [CNT_W-1:0] occ_nxt;
  logic [CNT_W-1:0] arr_cnt;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] ram_dout;
  logic             wr_busy;
  logic             push;
  logic             pop;
  logic             ld_ok;
  logic             arr_empty;
  logic             ld_arr;
  logic             bypass;
  logic             we;

  // Handshakes and output-stage steering.
  always_comb begin
    wr_prdy   = !wr_busy & !flush;
    push      = wr_pvld & wr_prdy;
    pop       = rd_pvld & rd_prdy;
    arr_cnt   = occupancy - CNT_W'(rd_pvld);
    arr_empty = (arr_cnt == '0);
    ld_ok     = pop | !rd_pvld;
    ld_arr    = ld_ok & !arr_empty;
    bypass    = ld_ok & arr_empty & push;
    we        = push & !bypass;
    occ_nxt   = occupancy + CNT_W'(push) - CNT_W'(pop);
  end

  // Count, flags, pointers and output valid.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      occupancy   <= '0;
      wr_busy     <= 1'b0;
      almost_full <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rd_pvld     <= 1'b0;
    end else if (flush) begin
      occupancy   <= '0;
      wr_busy     <= 1'b0;
      almost_full <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rd_pvld     <= 1'b0;
    end else begin
      occupancy   <= occ_nxt;
      wr_busy     <= (occ_nxt == FULL);
      almost_full <= (occ_nxt >= AFT);
      if (we)
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
      if (ld_arr)
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + AW'(1);
      if (ld_ok)
        rd_pvld <= ld_arr | bypass;
    end
  end

  // Output payload: array head first, else bypass.
  always_ff @(posedge nvdla_core_clk) begin
    if (ld_arr)
      rd_pd <= ram_dout;
    else if (bypass)
      rd_pd <= wr_pd;
  end

  sdp_nrdma_eg_flopram_rwsa #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .nvdla_core_clk (nvdla_core_clk),
    .we             (we),
    .wa             (wr_ptr),
    .di             (wr_pd),
    .ra             (rd_ptr),
    .dout           (ram_dout),
    .pwrbus_ram_pd  (pwrbus_ram_pd)
  );

endmodule

// File: tb/tb_sdp_nrdma_eg_ro_pfifo.sv
// Bench for sdp_nrdma_eg_ro_pfifo.
// Queue reference model, directed and random traffic.
module tb_sdp_nrdma_eg_ro_pfifo;
  import sdp_nrdma_eg_pkg::*;

  localparam int DEPTH = 4;
  localparam int CAP   = DEPTH + 1;
  localparam int AFT   = 4;

  logic           nvdla_core_clk;
  logic           nvdla_core_rstn;
  logic           wr_pvld;
  logic           wr_prdy;
  payload_t       wr_pd;
  logic           rd_pvld;
  logic           rd_prdy;
  payload_t       rd_pd;
  logic           flush;
  logic [2:0]     occupancy;
  logic           almost_full;
  logic [31:0]    pwrbus_ram_pd;

  payload_t q[$];
  int checks;
  int passed;
  int fails;
  int rand_pops;

  sdp_nrdma_eg_ro_pfifo dut (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .wr_pvld         (wr_pvld),
    .wr_prdy         (wr_prdy),
    .wr_pd           (wr_pd),
    .rd_pvld         (rd_pvld),
    .rd_prdy         (rd_prdy),
    .rd_pd           (rd_pd),
    .flush           (flush),
    .occupancy       (occupancy),
    .almost_full     (almost_full),
    .pwrbus_ram_pd   (pwrbus_ram_pd)
  );

  initial nvdla_core_clk = 1'b0;
  always #5 nvdla_core_clk = ~nvdla_core_clk;

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, compare against the queue model, advance.
  task automatic step(input bit wv, input payload_t d,
                      input bit rr, input bit fl,
                      output bit acc, output bit popd);
    bit e_prdy;
    bit e_vld;
    wr_pvld = wv;
    wr_pd   = d;
    rd_prdy = rr;
    flush   = fl;
    #1;
    e_prdy = (q.size() != CAP) && !fl;
    e_vld  = (q.size() != 0);
    chk("wr_prdy", 256'(wr_prdy), 256'(e_prdy));
    chk("rd_pvld", 256'(rd_pvld), 256'(e_vld));
    chk("occupancy", 256'(occupancy), 256'(q.size()));
    chk("almost_full", 256'(almost_full), 256'(q.size() >= AFT));
    if (e_vld) chk("rd_pd", rd_pd, q[0]);
    acc  = wv && e_prdy;
    popd = e_vld && rr;
    @(posedge nvdla_core_clk);
    #1;
    if (fl) q.delete();
    else begin
      if (popd) void'(q.pop_front());
      if (acc) q.push_back(d);
    end
  endtask

  function automatic payload_t rnd_pd(input int tag);
    payload_t v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
    v[15:0] = 16'(tag);
    return v;
  endfunction

  initial begin
    bit a;
    bit p;
    int sent;
    int cyc;
    checks = 0;
    passed = 0;
    fails = 0;
    rand_pops = 0;
    wr_pvld = 0;
    wr_pd = '0;
    rd_prdy = 0;
    flush = 0;
    pwrbus_ram_pd = '0;
    nvdla_core_rstn = 0;
    repeat (2) @(posedge nvdla_core_clk);
    #1;
    nvdla_core_rstn = 1;

    // Reset state, idle cycle.
    step(0, '0, 0, 0, a, p);

    // Fill to capacity with no reader.
    for (int i = 0; i < 5; i++) begin
      step(1, payload_t'(8'hA0 + i), 0, 0, a, p);
      chk("fill_acc", 256'(a), 256'(1));
    end
    // Full: held push not accepted.
    step(1, payload_t'(8'hB0), 0, 0, a, p);
    chk("full_block", 256'(a), 256'(0));
    // Single pop at full with push pending.
    step(1, payload_t'(8'hB0), 1, 0, a, p);
    step(1, payload_t'(8'hB0), 0, 0, a, p);
    chk("refill_acc", 256'(a), 256'(1));
    step(0, '0, 0, 0, a, p);
    for (int i = 0; i < 7; i++) step(0, '0, 1, 0, a, p);

    // Streaming push+pop every cycle.
    for (int i = 1; i <= 16; i++) step(1, payload_t'(i), 1, 0, a, p);
    for (int i = 0; i < 3; i++) step(0, '0, 1, 0, a, p);

    // Flush at occupancy 3 with push and pop pending.
    for (int i = 0; i < 3; i++) step(1, payload_t'(8'hC0 + i), 0, 0, a, p);
    step(1, payload_t'(8'h99), 1, 1, a, p);
    chk("flush_noacc", 256'(a), 256'(0));
    step(1, payload_t'(8'h55), 0, 0, a, p);
    step(0, '0, 0, 0, a, p);
    chk("post_flush_pd", rd_pd, payload_t'(8'h55));
    step(0, '0, 1, 0, a, p);
    step(0, '0, 1, 0, a, p);

    // Random traffic against the model.
    sent = 0;
    cyc = 0;
    while ((sent < 1000 || q.size() != 0) && cyc < 20000) begin
      bit wv;
      bit rr;
      wv = (sent < 1000) && ($urandom_range(0, 1) == 1);
      rr = ($urandom_range(0, 1) == 1);
      step(wv, rnd_pd(sent), rr, 0, a, p);
      if (a) sent++;
      if (p) rand_pops++;
      cyc++;
    end
    chk("rand_sent", 256'(sent), 256'(1000));
    chk("rand_pops", 256'(rand_pops), 256'(1000));
    step(0, '0, 0, 0, a, p);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
